branch_sequencer: RTL

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_pkg.sv | 18 +
 rtl/sat_counter.sv | 20 ++
 rtl/branch_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencer: condition codes and FSM states.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_BNE = 2'b00,
    BR_BEQ = 2'b01,
    BR_BGT = 2'b10,
    BR_BGE = 2'b11
  } br_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CMP  = 2'b01,
    S_EVAL = 2'b10,
    S_FIN  = 2'b11
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear (clear beats increment).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: CMP -> EVAL -> FIN control for an ALU compare,
// with saturating statistics for completed and taken branches.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       br_type,
  input  logic             zero_flag,
  input  logic             greater_flag,
  input  logic             clr_stats,
  output logic             ready,
  output logic             alu_cmp,
  output logic [1:0]       cond_sel,
  output logic             pc_write_cond,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count
);

  state_t state;
  br_t    type_q;
  logic   taken_n;

  always_comb begin
    taken_n = 1'b0;
    unique case (type_q)
      BR_BNE: taken_n = ~zero_flag;
      BR_BEQ: taken_n = zero_flag;
      BR_BGT: taken_n = greater_flag;
      BR_BGE: taken_n = zero_flag | greater_flag;
      default: taken_n = 1'b0;
    endcase
  end

  // Gated by reset so an aborted branch never loads the PC in its EVAL cycle.
  assign pc_write_cond = (state == S_EVAL) && taken_n && !reset;
  assign cond_sel      = ((state == S_EVAL) || (state == S_FIN)) ? type_q : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      type_q  <= BR_BNE;
      ready   <= 1'b1;
      alu_cmp <= 1'b0;
      done    <= 1'b0;
      taken   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_CMP;
            type_q  <= br_t'(br_type);
            ready   <= 1'b0;
            alu_cmp <= 1'b1;
          end
        end
        S_CMP: begin
          state   <= S_EVAL;
          alu_cmp <= 1'b0;
        end
        S_EVAL: begin
          state <= S_FIN;
          taken <= taken_n;
          done  <= 1'b1;
        end
        S_FIN: begin
          state <= S_IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (state == S_FIN),
    .count (br_count)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   ((state == S_FIN) && taken),
    .count (taken_count)
  );

endmodule
